// File: rtl/pitch_pkg.sv
// rtl/pitch_pkg.sv - shared state encoding, score bands and frequency limits for the pitch scorer
package pitch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FOLD,
        DIFF,
        GRADE
    } state_t;

    localparam int BAND0 = 10;
    localparam int BAND1 = 7;
    localparam int BAND2 = 4;
    localparam int BAND3 = 1;

    localparam int MIN_FREQ_DEF = 16;
    localparam int MAX_FREQ_DEF = 8000;

endpackage

// File: rtl/pitch_band_grader.sv
// rtl/pitch_band_grader.sv - combinational |sung-ref| to score band lookup, bands widen by one shift each
module pitch_band_grader
    import pitch_pkg::*;
#(
    parameter int W         = 16,
    parameter int SCORE_W   = 4,
    parameter int TOL_SHIFT = 6
) (
    input  logic [W-1:0]       i_diff,
    input  logic [W-1:0]       i_ref,
    output logic [SCORE_W-1:0] o_score
);

    logic [W-1:0] w_tol0;
    logic [W-1:0] w_tol1;
    logic [W-1:0] w_tol2;
    logic [W-1:0] w_tol3;

    assign w_tol0 = i_ref >> TOL_SHIFT;
    assign w_tol1 = i_ref >> (TOL_SHIFT - 1);
    assign w_tol2 = i_ref >> (TOL_SHIFT - 2);
    assign w_tol3 = i_ref >> (TOL_SHIFT - 3);

    always_comb begin
        o_score = '0;
        if (i_diff <= w_tol0) begin
            o_score = SCORE_W'(BAND0);
        end else if (i_diff <= w_tol1) begin
            o_score = SCORE_W'(BAND1);
        end else if (i_diff <= w_tol2) begin
            o_score = SCORE_W'(BAND2);
        end else if (i_diff <= w_tol3) begin
            o_score = SCORE_W'(BAND3);
        end
    end

endmodule

// File: rtl/pitch_scorer.sv
// rtl/pitch_scorer.sv - octave-folding graded pitch scorer; PITCH_SCORER_STATS_EN adds score totals
module pitch_scorer
    import pitch_pkg::*;
#(
    parameter int FREQ_W    = 15,
    parameter int SCORE_W   = 4,
    parameter int MIN_FREQ  = MIN_FREQ_DEF,
    parameter int MAX_FREQ  = MAX_FREQ_DEF,
    parameter int MAX_FOLDS = 9,
    parameter int TOL_SHIFT = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start,
    input  logic [FREQ_W-1:0]   sung_freq_in,
    input  logic [FREQ_W-1:0]   ref_freq_in,
    output logic                busy,
    output logic [SCORE_W-1:0]  score,
    output logic                score_valid,
    output logic signed [4:0]   oct_offset,
`ifdef PITCH_SCORER_STATS_EN
    output logic                err,
    input  logic                clr_stats,
    output logic [15:0]         total_score,
    output logic [11:0]         note_count
`else
    output logic                err
`endif
);

    localparam int SW = FREQ_W + 1;
    localparam logic signed [4:0] L_MAXF = 5'(MAX_FOLDS);

    state_t              r_state;
    state_t              w_next;
    logic                r_go;
    logic [SW-1:0]       r_sung;
    logic [FREQ_W-1:0]   r_ref;
    logic signed [4:0]   r_oct;
    logic                r_err_pend;
    logic [SW-1:0]       r_diff;
    logic [SCORE_W-1:0]  r_score;
    logic signed [4:0]   r_oct_out;
    logic                r_err_out;
    logic                r_valid;

    logic [SW-1:0]       w_ref_ext;
    logic [SW-1:0]       w_hi;
    logic [SW-1:0]       w_lo;
    logic                w_above;
    logic                w_below;
    logic                w_limit;
    logic                w_legal;
    logic                w_start_ok;
    logic [SW-1:0]       w_diff;
    logic [SCORE_W-1:0]  w_grade;

    assign w_ref_ext  = {1'b0, r_ref};
    assign w_hi       = w_ref_ext + (w_ref_ext >> 1);
    assign w_lo       = w_ref_ext - (w_ref_ext >> 2);
    assign w_above    = r_sung > w_hi;
    assign w_below    = r_sung < w_lo;
    assign w_limit    = (r_oct == L_MAXF) || (r_oct == -L_MAXF);
    assign w_legal    = (r_sung >= SW'(MIN_FREQ)) && (r_sung <= SW'(MAX_FREQ)) &&
                        (w_ref_ext >= SW'(MIN_FREQ)) && (w_ref_ext <= SW'(MAX_FREQ));
    assign w_diff     = (r_sung >= w_ref_ext) ? (r_sung - w_ref_ext) : (w_ref_ext - r_sung);
    // r_go marks the accept cycle, so a second start during it is also refused
    assign w_start_ok = start && (r_state == IDLE) && !r_go;

    pitch_band_grader #(
        .W         (SW),
        .SCORE_W   (SCORE_W),
        .TOL_SHIFT (TOL_SHIFT)
    ) u_grader (
        .i_diff  (r_diff),
        .i_ref   (w_ref_ext),
        .o_score (w_grade)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (enable) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_go) w_next = CHECK;
            CHECK:   w_next = w_legal ? FOLD : GRADE;
            FOLD:    begin
                if (w_above || w_below) begin
                    w_next = w_limit ? GRADE : FOLD;
                end else begin
                    w_next = DIFF;
                end
            end
            DIFF:    w_next = GRADE;
            GRADE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go       <= 1'b0;
            r_sung     <= '0;
            r_ref      <= '0;
            r_oct      <= '0;
            r_err_pend <= 1'b0;
            r_diff     <= '0;
            r_score    <= '0;
            r_oct_out  <= '0;
            r_err_out  <= 1'b0;
            r_valid    <= 1'b0;
        end else if (enable) begin
            r_valid <= 1'b0;
            r_go    <= w_start_ok;
            if (w_start_ok) begin
                r_sung     <= {1'b0, sung_freq_in};
                r_ref      <= ref_freq_in;
                r_oct      <= '0;
                r_err_pend <= 1'b0;
            end
            case (r_state)
                CHECK: if (!w_legal) r_err_pend <= 1'b1;
                FOLD: begin
                    if ((w_above || w_below) && w_limit) begin
                        r_err_pend <= 1'b1;
                    end else if (w_above) begin
                        r_sung <= r_sung >> 1;
                        r_oct  <= r_oct + 5'sd1;
                    end else if (w_below) begin
                        r_sung <= r_sung << 1;
                        r_oct  <= r_oct - 5'sd1;
                    end
                end
                DIFF:  r_diff <= w_diff;
                GRADE: begin
                    r_valid <= 1'b1;
                    if (r_err_pend) begin
                        r_score   <= '0;
                        r_oct_out <= '0;
                        r_err_out <= 1'b1;
                    end else begin
                        r_score   <= w_grade;
                        r_oct_out <= r_oct;
                        r_err_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_go || (r_state != IDLE);
    assign score       = r_score;
    assign score_valid = r_valid;
    assign oct_offset  = r_oct_out;
    assign err         = r_err_out;

`ifdef PITCH_SCORER_STATS_EN
    logic [15:0] r_total;
    logic [11:0] r_count;
    logic [16:0] w_sum;

    assign w_sum = {1'b0, r_total} + 17'(r_score);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
            r_count <= '0;
        end else if (enable) begin
            if (clr_stats) begin
                r_total <= '0;
                r_count <= '0;
            end else if (r_valid) begin
                r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
                r_count <= r_count + 12'd1;
            end
        end
    end

    assign total_score = r_total;
    assign note_count  = r_count;
`endif

endmodule

// File: tb/tb_pitch_scorer.sv
// tb/tb_pitch_scorer.sv - randomized and directed checks of pitch_scorer against an arithmetic reference model
module tb_pitch_scorer;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b1;
    logic              start = 1'b0;
    logic [14:0]       sung_freq_in = '0;
    logic [14:0]       ref_freq_in = '0;
    logic              busy;
    logic [3:0]        score;
    logic              score_valid;
    logic signed [4:0] oct_offset;
    logic              err;
`ifdef PITCH_SCORER_STATS_EN
    logic              clr_stats = 1'b0;
    logic [15:0]       total_score;
    logic [11:0]       note_count;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    pitch_scorer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .start        (start),
        .sung_freq_in (sung_freq_in),
        .ref_freq_in  (ref_freq_in),
        .busy         (busy),
        .score        (score),
        .score_valid  (score_valid),
        .oct_offset   (oct_offset),
`ifdef PITCH_SCORER_STATS_EN
        .err          (err),
        .clr_stats    (clr_stats),
        .total_score  (total_score),
        .note_count   (note_count)
`else
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: fold by halving/doubling until within [ref-ref/4, ref+ref/2], then grade.
    function automatic void model(input int s, input int r, output int sc, output int off,
                                  output int e, output int lat);
        int cur;
        int d;
        sc = 0; off = 0; e = 0; lat = 3;
        if (s < 16 || s > 8000 || r < 16 || r > 8000) begin
            e = 1;
            return;
        end
        cur = s;
        while (1) begin
            if (cur > r + r / 2 || cur < r - r / 4) begin
                if (off == 9 || off == -9) begin
                    e = 1; off = 0; lat = 9 + 4;
                    return;
                end
                if (cur > r + r / 2) begin cur = cur / 2; off++; end
                else begin cur = cur * 2; off--; end
            end else begin
                break;
            end
        end
        d = (cur > r) ? cur - r : r - cur;
        if (d <= r / 64)      sc = 10;
        else if (d <= r / 32) sc = 7;
        else if (d <= r / 16) sc = 4;
        else if (d <= r / 8)  sc = 1;
        lat = (off < 0 ? -off : off) + 5;
    endfunction

    task automatic run_req(input int s, input int r, input int hold_at, input bit extra);
        int sc, off, e, lat, k;
        bit got, busy_ok, stray;
        model(s, r, sc, off, e, lat);
        @(negedge clk);
        sung_freq_in = 15'(s);
        ref_freq_in  = 15'(r);
        start  = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        k = 0; got = 0; busy_ok = 1;
        while (!got && k < 200) begin
            @(negedge clk);
            enable = !(hold_at >= 0 && k >= hold_at && k < hold_at + 3);
            if (extra && k == 2) begin
                start = 1'b1;
                sung_freq_in = '0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            k++;
            #1;
            if (score_valid) got = 1;
            else if (!busy) busy_ok = 0;
        end
        start = 1'b0;
        check("valid_seen", got, 1);
        check("latency", k, lat + (hold_at >= 0 ? 3 : 0));
        check("score", score, sc);
        check("oct_offset", $signed(oct_offset), off);
        check("err", err, e);
        check("busy_at_valid", busy, 0);
        check("busy_during", busy_ok, 1);
        @(negedge clk) enable = 1'b0;
        @(posedge clk) #1 check("valid_held", score_valid, 1);
        @(negedge clk) enable = 1'b1;
        @(posedge clk) #1 check("valid_drop", score_valid, 0);
        if (extra) begin
            stray = 0;
            repeat (12) begin
                @(posedge clk) #1;
                if (score_valid || busy) stray = 1;
            end
            check("no_queued_start", stray, 0);
        end
    endtask

    initial begin
        bit seen;
        #1;
        check("rst_busy", busy, 0);
        check("rst_score", score, 0);
        check("rst_valid", score_valid, 0);
        check("rst_oct", $signed(oct_offset), 0);
        check("rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;

        run_req(440, 440, -1, 0);
        run_req(1760, 440, -1, 0);
        run_req(452, 440, -1, 0);
        run_req(500, 440, -1, 0);
        run_req(0, 440, -1, 0);
        run_req(440, 8001, -1, 0);
        run_req(8000, 16, -1, 0);
        run_req(16, 8000, -1, 0);
        run_req(15, 440, -1, 0);
        run_req(1760, 440, 3, 0);
        run_req(1760, 440, -1, 1);

        for (int i = 0; i < 40; i++) begin
            int r, s, sh;
            r = (i % 8 == 7) ? int'($urandom_range(0, 9000)) : int'($urandom_range(16, 8000));
            s = r + int'($urandom_range(0, r / 4)) - r / 8;
            sh = int'($urandom_range(0, 6)) - 3;
            s = (sh >= 0) ? (s << sh) : (s >> -sh);
            if (i % 10 == 9) s = int'($urandom_range(0, 20));
            run_req(s & 32767, r, -1, 0);
        end

        run_req(452, 440, -1, 0);
        @(negedge clk);
        sung_freq_in = 15'd1760;
        ref_freq_in  = 15'd440;
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_score", score, 0);
        check("abort_valid", score_valid, 0);
        check("abort_err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk) #1;
            if (score_valid) seen = 1;
        end
        check("abort_no_valid", seen, 0);

`ifdef PITCH_SCORER_STATS_EN
        @(negedge clk) clr_stats = 1'b1;
        @(negedge clk) clr_stats = 1'b0;
        run_req(440, 440, -1, 0);
        run_req(452, 440, -1, 0);
        run_req(0, 440, -1, 0);
        @(posedge clk) #1;
        check("stats_total", total_score, 17);
        check("stats_count", note_count, 3);
        @(negedge clk) clr_stats = 1'b1;
        @(negedge clk) clr_stats = 1'b0;
        #1;
        check("stats_clr_total", total_score, 0);
        check("stats_clr_count", note_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
